toll_booth_ctrl: RTL and testbench
==================================

# toll_booth_ctrl

Sequential, parametrised successor to the combinational toll-rate classifier. It accepts one vehicle at a time through a valid/ready handshake and classifies it into HIGH/MED/LOW/ERR with the existing rate equations. It then collects coins against a parametrised price, opens the gate for a fixed time and returns change. It sits between the lane sensors / coin acceptor and the barrier actuator, and keeps saturating statistics counters.

## Interface
Parameters:
- COIN_W, 4: coin value width
- AMT_W, 8: amount-due / paid / change width
- CNT_W, 16: statistics counter width
- PRICE_HIGH, 5; PRICE_MED, 3; PRICE_LOW, 1: tariff per rate (each < 2^AMT_W)
- TIMEOUT, 16: max cycles spent in PAY (≥1)
- GATE_CYCLES, 4: gate-open duration in cycles (≥1)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  **synchronous, active-high** reset
- veh_valid  in  1  vehicle present with attributes valid
- veh_ready  out  1  controller idle, accepts vehicle
- wd, rh, ln, ht  in  1 each  weekday, rush hour, lane flag, heavy truck; sampled on handshake
- coin_valid  in  1  one coin this cycle
- coin_value  in  COIN_W  coin value
- coin_ready  out  1  coins accepted (state PAY)
- rate  out  2  latched class: 0 LOW, 1 MED, 2 HIGH, 3 ERR
- amount_due  out  AMT_W  latched price of current vehicle
- gate_open  out  1  barrier open
- change_valid  out  1  one-cycle pulse, change present
- change  out  AMT_W  change/refund value, valid with change_valid
- err_pulse  out  1  one-cycle pulse, vehicle rejected
- timeout_pulse  out  1  one-cycle pulse, payment aborted
- veh_cnt, err_cnt, revenue  out  CNT_W each  saturating statistics

## Operation
- Classification, evaluated on sampled inputs:
  - ERR = ln&rh
  - HIGH = (!rh&ht) | (!ln&ht) | (wd&rh&!ln)
  - MED = (ln&rh) | (!wd&!ln&!ht) | (!rh&!ln&!ht)
  - LOW = !rh&ln&!ht
  - Priority ERR > HIGH > MED > LOW; every input combination maps to exactly one rate.
- States IDLE, PAY, GATE. veh_ready = (state==IDLE); coin_ready = (state==PAY).
- IDLE, handshake (veh_valid&veh_ready):
  - ERR: rate=3, err_pulse next cycle, err_cnt+1, remain IDLE.
  - Otherwise: latch rate, amount_due=PRICE_x, paid=0, tmo=0, go PAY.
- PAY, each cycle:
  - sum = paid + (coin_valid ? coin_value : 0), saturating at 2^AMT_W-1.
  - If sum ≥ amount_due: go GATE with gate_open=1, change=sum−amount_due, change_valid=1, veh_cnt+1, revenue+=amount_due (saturating).
  - Else if tmo==TIMEOUT−1: go IDLE, change=sum (full refund), change_valid=1, timeout_pulse=1.
  - Else paid=sum, tmo+1.
  - Payment completion takes precedence over timeout in the same cycle.
  - A price of 0 completes in the first PAY cycle.
- GATE: gate_open held GATE_CYCLES cycles, then IDLE. Coins outside PAY are ignored and not counted.
- All counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- All outputs are registered.
- Reset values: state IDLE, veh_ready=1, coin_ready=0, rate=0, amount_due=0, gate_open=0, change=0, change_valid=0, err_pulse=0, timeout_pulse=0, all counters 0.
- Handshake at cycle T: PAY (coin_ready=1) from T+1, or err_pulse=1 at T+1 with veh_ready remaining 1.
- Completing coin at cycle C: gate_open=1 and change_valid=1 at C+1. gate_open is high for cycles C+1 … C+GATE_CYCLES. veh_ready=1 at C+GATE_CYCLES+1.
- Timeout: PAY entered at T+1 with no completion. timeout_pulse, change_valid and veh_ready=1 at T+1+TIMEOUT.
- Reset mid-operation: on the next edge all outputs take reset values, gate closes, collected money is discarded (no refund pulse), counters clear.
- veh_valid while not ready: ignored; the attributes must be held by the source.

## Test plan
- Reset then wd=1,rh=0,ln=1,ht=0 (LOW): rate=0, amount_due=1. Coin 2 at C → gate_open C+1..C+4, change_valid with change=1, veh_cnt=1, revenue=1.
- rh=1,ln=1 (ERR): err_pulse one cycle at T+1, err_cnt=1, no PAY, gate never opens, veh_ready stays 1.
- wd=1,rh=1,ln=0,ht=0 (HIGH, due 5): coins 2,2 on separate cycles, then coin 1 on the TIMEOUT-th PAY cycle → gate opens (precedence), change=0.
- MED (wd=0,ln=0,ht=0), one coin of 1, then idle → at T+17 timeout_pulse=1, change_valid=1, change=1, veh_cnt unchanged.
- Assert rst during GATE and during PAY with paid=2 → next cycle gate_open=0, veh_ready=1, counters 0, no change_valid.
- CNT_W=2, four paid LOW vehicles → veh_cnt saturates at 3, revenue saturates at 3.

Source files
------------

// File: rtl/toll_booth_ctrl.sv
// ---------------------------------------------------------------------------
// toll_booth_ctrl
//
// Sequential toll booth controller. Accepts one vehicle at a time through a
// valid/ready handshake, classifies it (LOW/MED/HIGH/ERR) from its sampled
// attributes, collects coins against the tariff of that class, opens the
// barrier for a fixed number of cycles and returns change. A payment that
// does not complete in TIMEOUT cycles is aborted with a full refund.
// Saturating statistics counters track served vehicles, rejected vehicles
// and revenue.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   veh_valid/ready     vehicle handshake (ready only while idle)
//   wd, rh, ln, ht      weekday, rush hour, lane flag, heavy truck
//   coin_valid/value    one coin per cycle, taken only while paying
//   coin_ready          high while the controller is collecting coins
//   rate, amount_due    latched class (0 LOW,1 MED,2 HIGH,3 ERR) and price
//   gate_open           barrier open
//   change_valid/change one-cycle change or refund report
//   err_pulse           one-cycle pulse, vehicle rejected
//   timeout_pulse       one-cycle pulse, payment aborted
//   veh_cnt, err_cnt,
//   revenue             saturating statistics
// ---------------------------------------------------------------------------
module toll_booth_ctrl #(
    parameter int COIN_W      = 4,
    parameter int AMT_W       = 8,
    parameter int CNT_W       = 16,
    parameter int PRICE_HIGH  = 5,
    parameter int PRICE_MED   = 3,
    parameter int PRICE_LOW   = 1,
    parameter int TIMEOUT     = 16,
    parameter int GATE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              veh_valid,
    output logic              veh_ready,
    input  logic              wd,
    input  logic              rh,
    input  logic              ln,
    input  logic              ht,
    input  logic              coin_valid,
    input  logic [COIN_W-1:0] coin_value,
    output logic              coin_ready,
    output logic [1:0]        rate,
    output logic [AMT_W-1:0]  amount_due,
    output logic              gate_open,
    output logic              change_valid,
    output logic [AMT_W-1:0]  change,
    output logic              err_pulse,
    output logic              timeout_pulse,
    output logic [CNT_W-1:0]  veh_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  revenue
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PAY  = 2'd1,
        ST_GATE = 2'd2
    } state_t;

    // Sum widths leave one carry bit so saturation can be detected.
    localparam int PSUM_W = ((AMT_W > COIN_W) ? AMT_W : COIN_W) + 1;
    localparam int RSUM_W = ((CNT_W > AMT_W) ? CNT_W : AMT_W) + 1;
    localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GCNT_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

    localparam logic [AMT_W-1:0]  AMT_MAX   = {AMT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [GCNT_W-1:0] GATE_LOAD = GCNT_W'(GATE_CYCLES - 1);

    localparam logic [AMT_W-1:0] PRICE_HIGH_C = AMT_W'(PRICE_HIGH);
    localparam logic [AMT_W-1:0] PRICE_MED_C  = AMT_W'(PRICE_MED);
    localparam logic [AMT_W-1:0] PRICE_LOW_C  = AMT_W'(PRICE_LOW);

    localparam logic [1:0] RATE_LOW  = 2'd0;
    localparam logic [1:0] RATE_MED  = 2'd1;
    localparam logic [1:0] RATE_HIGH = 2'd2;
    localparam logic [1:0] RATE_ERR  = 2'd3;

    // Rate equations evaluated in priority order ERR > HIGH > MED > LOW.
    function automatic logic [1:0] classify(input logic a_wd, input logic a_rh,
                                            input logic a_ln, input logic a_ht);
        logic [1:0] r;
        if (a_ln & a_rh) begin
            r = RATE_ERR;
        end else if ((!a_rh & a_ht) | (!a_ln & a_ht) | (a_wd & a_rh & !a_ln)) begin
            r = RATE_HIGH;
        end else if ((a_ln & a_rh) | (!a_wd & !a_ln & !a_ht) | (!a_rh & !a_ln & !a_ht)) begin
            r = RATE_MED;
        end else begin
            r = RATE_LOW;
        end
        return r;
    endfunction

    function automatic logic [AMT_W-1:0] price_of(input logic [1:0] r);
        logic [AMT_W-1:0] p;
        case (r)
            RATE_HIGH: p = PRICE_HIGH_C;
            RATE_MED:  p = PRICE_MED_C;
            RATE_LOW:  p = PRICE_LOW_C;
            default:   p = {AMT_W{1'b0}};
        endcase
        return p;
    endfunction

    state_t             state_r, state_nxt_s;
    logic [1:0]         rate_r, rate_nxt_s;
    logic [AMT_W-1:0]   amount_due_r, amount_due_nxt_s;
    logic [AMT_W-1:0]   paid_r, paid_nxt_s;
    logic [TMO_W-1:0]   tmo_r, tmo_nxt_s;
    logic [GCNT_W-1:0]  gate_cnt_r, gate_cnt_nxt_s;
    logic               gate_open_r, gate_open_nxt_s;
    logic [AMT_W-1:0]   change_r, change_nxt_s;
    logic               change_valid_r, change_valid_nxt_s;
    logic               err_pulse_r, err_pulse_nxt_s;
    logic               timeout_pulse_r, timeout_pulse_nxt_s;
    logic               veh_ready_r, veh_ready_nxt_s;
    logic               coin_ready_r, coin_ready_nxt_s;
    logic [CNT_W-1:0]   veh_cnt_r, veh_cnt_nxt_s;
    logic [CNT_W-1:0]   err_cnt_r, err_cnt_nxt_s;
    logic [CNT_W-1:0]   revenue_r, revenue_nxt_s;

    logic [1:0]         class_s;
    logic [PSUM_W-1:0]  psum_wide_s;
    logic [AMT_W-1:0]   pay_sum_s;
    logic [RSUM_W-1:0]  rsum_wide_s;
    logic [CNT_W-1:0]   rev_sum_s;

    assign class_s = classify(wd, rh, ln, ht);

    // Saturating running payment and saturating revenue update.
    always_comb begin
        psum_wide_s = PSUM_W'(paid_r) + (coin_valid ? PSUM_W'(coin_value) : {PSUM_W{1'b0}});
        if (psum_wide_s > PSUM_W'(AMT_MAX)) begin
            pay_sum_s = AMT_MAX;
        end else begin
            pay_sum_s = psum_wide_s[AMT_W-1:0];
        end
        rsum_wide_s = RSUM_W'(revenue_r) + RSUM_W'(amount_due_r);
        if (rsum_wide_s > RSUM_W'(CNT_MAX)) begin
            rev_sum_s = CNT_MAX;
        end else begin
            rev_sum_s = rsum_wide_s[CNT_W-1:0];
        end
    end

    // Next-state and next-output logic of the booth FSM.
    always_comb begin
        state_nxt_s         = state_r;
        rate_nxt_s          = rate_r;
        amount_due_nxt_s    = amount_due_r;
        paid_nxt_s          = paid_r;
        tmo_nxt_s           = tmo_r;
        gate_cnt_nxt_s      = gate_cnt_r;
        gate_open_nxt_s     = 1'b0;
        change_nxt_s        = change_r;
        change_valid_nxt_s  = 1'b0;
        err_pulse_nxt_s     = 1'b0;
        timeout_pulse_nxt_s = 1'b0;
        veh_cnt_nxt_s       = veh_cnt_r;
        err_cnt_nxt_s       = err_cnt_r;
        revenue_nxt_s       = revenue_r;

        case (state_r)
            ST_IDLE: begin
                if (veh_valid) begin
                    if (class_s == RATE_ERR) begin
                        rate_nxt_s       = RATE_ERR;
                        amount_due_nxt_s = {AMT_W{1'b0}};
                        err_pulse_nxt_s  = 1'b1;
                        if (err_cnt_r != CNT_MAX) begin
                            err_cnt_nxt_s = err_cnt_r + CNT_W'(1'b1);
                        end else begin
                            err_cnt_nxt_s = err_cnt_r;
                        end
                    end else begin
                        rate_nxt_s       = class_s;
                        amount_due_nxt_s = price_of(class_s);
                        paid_nxt_s       = {AMT_W{1'b0}};
                        tmo_nxt_s        = {TMO_W{1'b0}};
                        state_nxt_s      = ST_PAY;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PAY: begin
                // Completion is tested first so a last-cycle coin still wins.
                if (pay_sum_s >= amount_due_r) begin
                    state_nxt_s        = ST_GATE;
                    gate_open_nxt_s    = 1'b1;
                    gate_cnt_nxt_s     = GATE_LOAD;
                    change_nxt_s       = pay_sum_s - amount_due_r;
                    change_valid_nxt_s = 1'b1;
                    revenue_nxt_s      = rev_sum_s;
                    if (veh_cnt_r != CNT_MAX) begin
                        veh_cnt_nxt_s = veh_cnt_r + CNT_W'(1'b1);
                    end else begin
                        veh_cnt_nxt_s = veh_cnt_r;
                    end
                end else if (tmo_r == TMO_LAST) begin
                    state_nxt_s         = ST_IDLE;
                    change_nxt_s        = pay_sum_s;
                    change_valid_nxt_s  = 1'b1;
                    timeout_pulse_nxt_s = 1'b1;
                end else begin
                    paid_nxt_s = pay_sum_s;
                    tmo_nxt_s  = tmo_r + TMO_W'(1'b1);
                end
            end
            ST_GATE: begin
                if (gate_cnt_r == {GCNT_W{1'b0}}) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    gate_open_nxt_s = 1'b1;
                    gate_cnt_nxt_s  = gate_cnt_r - GCNT_W'(1'b1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        veh_ready_nxt_s  = (state_nxt_s == ST_IDLE);
        coin_ready_nxt_s = (state_nxt_s == ST_PAY);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            rate_r          <= 2'd0;
            amount_due_r    <= {AMT_W{1'b0}};
            paid_r          <= {AMT_W{1'b0}};
            tmo_r           <= {TMO_W{1'b0}};
            gate_cnt_r      <= {GCNT_W{1'b0}};
            gate_open_r     <= 1'b0;
            change_r        <= {AMT_W{1'b0}};
            change_valid_r  <= 1'b0;
            err_pulse_r     <= 1'b0;
            timeout_pulse_r <= 1'b0;
            veh_ready_r     <= 1'b1;
            coin_ready_r    <= 1'b0;
            veh_cnt_r       <= {CNT_W{1'b0}};
            err_cnt_r       <= {CNT_W{1'b0}};
            revenue_r       <= {CNT_W{1'b0}};
        end else begin
            state_r         <= state_nxt_s;
            rate_r          <= rate_nxt_s;
            amount_due_r    <= amount_due_nxt_s;
            paid_r          <= paid_nxt_s;
            tmo_r           <= tmo_nxt_s;
            gate_cnt_r      <= gate_cnt_nxt_s;
            gate_open_r     <= gate_open_nxt_s;
            change_r        <= change_nxt_s;
            change_valid_r  <= change_valid_nxt_s;
            err_pulse_r     <= err_pulse_nxt_s;
            timeout_pulse_r <= timeout_pulse_nxt_s;
            veh_ready_r     <= veh_ready_nxt_s;
            coin_ready_r    <= coin_ready_nxt_s;
            veh_cnt_r       <= veh_cnt_nxt_s;
            err_cnt_r       <= err_cnt_nxt_s;
            revenue_r       <= revenue_nxt_s;
        end
    end

    assign veh_ready     = veh_ready_r;
    assign coin_ready    = coin_ready_r;
    assign rate          = rate_r;
    assign amount_due    = amount_due_r;
    assign gate_open     = gate_open_r;
    assign change_valid  = change_valid_r;
    assign change        = change_r;
    assign err_pulse     = err_pulse_r;
    assign timeout_pulse = timeout_pulse_r;
    assign veh_cnt       = veh_cnt_r;
    assign err_cnt       = err_cnt_r;
    assign revenue       = revenue_r;

endmodule

// File: tb/tb_toll_booth_ctrl.sv
// ---------------------------------------------------------------------------
// tb_toll_booth_ctrl
//
// Drives vehicles and coins into two controllers sharing all inputs: one with
// default parameters and one with 2-bit statistics counters for saturation.
// Expected behaviour comes from a transaction-level model: the class from the
// rate equations, the price table, a running integer payment and plain
// integer counters clipped to the counter range.
// ---------------------------------------------------------------------------
module tb_toll_booth_ctrl;

    localparam int TIMEOUT     = 16;
    localparam int GATE_CYCLES = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       veh_valid, wd, rh, ln, ht, coin_valid;
    logic [3:0] coin_value;

    logic        veh_ready, coin_ready, gate_open, change_valid, err_pulse, timeout_pulse;
    logic [1:0]  rate;
    logic [7:0]  amount_due, change;
    logic [15:0] veh_cnt, err_cnt, revenue;

    logic        s_veh_ready, s_coin_ready, s_gate_open, s_change_valid, s_err_pulse, s_timeout_pulse;
    logic [1:0]  s_rate;
    logic [7:0]  s_amount_due, s_change;
    logic [1:0]  s_veh_cnt, s_err_cnt, s_revenue;

    int total = 0;
    int bad   = 0;
    int exp_veh, exp_err, exp_rev;
    int plan [32];

    always #5 clk = ~clk;

    toll_booth_ctrl dut (
        .clk(clk), .rst(rst), .veh_valid(veh_valid), .veh_ready(veh_ready),
        .wd(wd), .rh(rh), .ln(ln), .ht(ht),
        .coin_valid(coin_valid), .coin_value(coin_value), .coin_ready(coin_ready),
        .rate(rate), .amount_due(amount_due), .gate_open(gate_open),
        .change_valid(change_valid), .change(change), .err_pulse(err_pulse),
        .timeout_pulse(timeout_pulse), .veh_cnt(veh_cnt), .err_cnt(err_cnt),
        .revenue(revenue)
    );

    toll_booth_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .veh_valid(veh_valid), .veh_ready(s_veh_ready),
        .wd(wd), .rh(rh), .ln(ln), .ht(ht),
        .coin_valid(coin_valid), .coin_value(coin_value), .coin_ready(s_coin_ready),
        .rate(s_rate), .amount_due(s_amount_due), .gate_open(s_gate_open),
        .change_valid(s_change_valid), .change(s_change), .err_pulse(s_err_pulse),
        .timeout_pulse(s_timeout_pulse), .veh_cnt(s_veh_cnt), .err_cnt(s_err_cnt),
        .revenue(s_revenue)
    );

    function automatic int model_rate(bit a_wd, bit a_rh, bit a_ln, bit a_ht);
        if (a_ln && a_rh) return 3;
        if ((!a_rh && a_ht) || (!a_ln && a_ht) || (a_wd && a_rh && !a_ln)) return 2;
        if ((!a_wd && !a_ln && !a_ht) || (!a_rh && !a_ln && !a_ht)) return 1;
        return 0;
    endfunction

    function automatic int model_price(int r);
        if (r == 2) return 5;
        if (r == 1) return 3;
        return 1;
    endfunction

    function automatic int sat3(int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_plan;
        for (int i = 0; i < 32; i++) plan[i] = -1;
    endtask

    // One full vehicle transaction following plan[] as the per-PAY-cycle coins.
    task automatic run_vehicle(input bit a_wd, input bit a_rh, input bit a_ln,
                               input bit a_ht, input bit noise, input string tag);
        int r, due, paid;
        logic [13:0] exp_v, got_v;
        total++;
        if (veh_ready !== 1'b1) begin
            bad++; $display("FAIL %s_ready_before got=%0b exp=1", tag, veh_ready);
        end
        wd = a_wd; rh = a_rh; ln = a_ln; ht = a_ht; veh_valid = 1'b1;
        tick;
        veh_valid = 1'b0;
        r = model_rate(a_wd, a_rh, a_ln, a_ht);
        if (r == 3) begin
            exp_err++;
            total++;
            got_v = {9'd0, err_pulse, veh_ready, coin_ready, rate};
            exp_v = {9'd0, 1'b1, 1'b1, 1'b0, 2'd3};
            if (got_v !== exp_v) begin
                bad++; $display("FAIL %s_err_flags got=%0h exp=%0h", tag, got_v, exp_v);
            end
            total++;
            if (err_cnt !== 16'(exp_err) || s_err_cnt !== 2'(sat3(exp_err))) begin
                bad++; $display("FAIL %s_err_cnt got=%0d/%0d exp=%0d/%0d", tag,
                                err_cnt, s_err_cnt, exp_err, sat3(exp_err));
            end
            tick;
            total++;
            if ({err_pulse, gate_open, coin_ready, veh_ready} !== 4'b0001) begin
                bad++; $display("FAIL %s_err_after got=%0b exp=0001", tag,
                                {err_pulse, gate_open, coin_ready, veh_ready});
            end
            return;
        end
        due = model_price(r);
        total++;
        got_v = {coin_ready, veh_ready, err_pulse, rate, 1'b0, amount_due};
        exp_v = {1'b1, 1'b0, 1'b0, 2'(r), 1'b0, 8'(due)};
        if (got_v !== exp_v) begin
            bad++; $display("FAIL %s_accept got=%0h exp=%0h", tag, got_v, exp_v);
        end
        paid = 0;
        for (int k = 0; k < TIMEOUT; k++) begin
            if (plan[k] >= 0) begin
                coin_valid = 1'b1;
                coin_value = 4'(plan[k]);
                paid += plan[k];
                if (paid > 255) paid = 255;
            end
            if (noise && $urandom_range(0, 3) == 0) begin
                veh_valid = 1'b1;
                {wd, rh, ln, ht} = 4'($urandom_range(0, 15));
            end
            tick;
            coin_valid = 1'b0;
            veh_valid  = 1'b0;
            if (paid >= due) begin
                exp_veh++;
                exp_rev += due;
                total++;
                got_v = {1'b0, gate_open, change_valid, timeout_pulse, coin_ready, 1'b0, change};
                exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'(paid - due)};
                if (got_v !== exp_v) begin
                    bad++; $display("FAIL %s_paid got=%0h exp=%0h", tag, got_v, exp_v);
                end
                total++;
                if (veh_cnt !== 16'(exp_veh) || revenue !== 16'(exp_rev) ||
                    s_veh_cnt !== 2'(sat3(exp_veh)) || s_revenue !== 2'(sat3(exp_rev))) begin
                    bad++; $display("FAIL %s_counters got=%0d,%0d,%0d,%0d exp=%0d,%0d,%0d,%0d",
                                    tag, veh_cnt, revenue, s_veh_cnt, s_revenue,
                                    exp_veh, exp_rev, sat3(exp_veh), sat3(exp_rev));
                end
                for (int g = 1; g <= GATE_CYCLES; g++) begin
                    coin_valid = 1'($urandom_range(0, 1));
                    coin_value = 4'($urandom_range(1, 15));
                    tick;
                    coin_valid = 1'b0;
                    total++;
                    if (g < GATE_CYCLES) begin
                        if ({gate_open, change_valid, coin_ready, veh_ready} !== 4'b1000) begin
                            bad++; $display("FAIL %s_gate_hold%0d got=%0b exp=1000", tag, g,
                                            {gate_open, change_valid, coin_ready, veh_ready});
                        end
                    end else begin
                        if ({gate_open, change_valid, veh_ready} !== 3'b001 ||
                            veh_cnt !== 16'(exp_veh) || revenue !== 16'(exp_rev)) begin
                            bad++; $display("FAIL %s_gate_close got=%0b,%0d,%0d exp=001,%0d,%0d", tag,
                                            {gate_open, change_valid, veh_ready}, veh_cnt, revenue,
                                            exp_veh, exp_rev);
                        end
                    end
                end
                return;
            end else if (k == TIMEOUT - 1) begin
                total++;
                got_v = {1'b0, timeout_pulse, change_valid, veh_ready, gate_open, 1'b0, change};
                exp_v = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'(paid)};
                if (got_v !== exp_v) begin
                    bad++; $display("FAIL %s_timeout got=%0h exp=%0h", tag, got_v, exp_v);
                end
                total++;
                if (veh_cnt !== 16'(exp_veh) || revenue !== 16'(exp_rev)) begin
                    bad++; $display("FAIL %s_timeout_cnt got=%0d,%0d exp=%0d,%0d", tag,
                                    veh_cnt, revenue, exp_veh, exp_rev);
                end
                tick;
                total++;
                if ({timeout_pulse, change_valid, veh_ready} !== 3'b001) begin
                    bad++; $display("FAIL %s_timeout_after got=%0b exp=001", tag,
                                    {timeout_pulse, change_valid, veh_ready});
                end
                return;
            end else begin
                total++;
                if ({coin_ready, change_valid, gate_open, timeout_pulse} !== 4'b1000) begin
                    bad++; $display("FAIL %s_paying%0d got=%0b exp=1000", tag, k,
                                    {coin_ready, change_valid, gate_open, timeout_pulse});
                end
            end
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        veh_valid = 1'b0; coin_valid = 1'b0;
        exp_veh = 0; exp_err = 0; exp_rev = 0;
    endtask

    task automatic test_reset;
        rst = 1'b1; veh_valid = 1'b1; coin_valid = 1'b1; coin_value = 4'd7;
        wd = 1'b1; rh = 1'b0; ln = 1'b0; ht = 1'b1;
        tick;
        tick;
        total++;
        if ({veh_ready, coin_ready, rate, amount_due, gate_open, change, change_valid,
             err_pulse, timeout_pulse} !== {1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL reset_outputs got=%0b/%0b/%0d/%0d/%0b/%0d/%0b/%0b/%0b exp=1/0/0/0/0/0/0/0/0",
                            veh_ready, coin_ready, rate, amount_due, gate_open, change,
                            change_valid, err_pulse, timeout_pulse);
        end
        total++;
        if (veh_cnt !== 16'd0 || err_cnt !== 16'd0 || revenue !== 16'd0 ||
            s_veh_cnt !== 2'd0 || s_err_cnt !== 2'd0 || s_revenue !== 2'd0) begin
            bad++; $display("FAIL reset_counters got=%0d,%0d,%0d exp=0,0,0", veh_cnt, err_cnt, revenue);
        end
        rst = 1'b0; veh_valid = 1'b0; coin_valid = 1'b0;
        exp_veh = 0; exp_err = 0; exp_rev = 0;
    endtask

    task automatic test_low;
        clear_plan();
        plan[0] = 2;
        run_vehicle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "low");
    endtask

    task automatic test_err;
        run_vehicle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "err");
        run_vehicle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "err2");
    endtask

    task automatic test_precedence;
        clear_plan();
        plan[0] = 2; plan[3] = 2; plan[TIMEOUT-1] = 1;
        run_vehicle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "precedence");
    endtask

    task automatic test_timeout;
        clear_plan();
        plan[0] = 1;
        run_vehicle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "timeout");
    endtask

    task automatic test_reset_mid;
        // Reset while the gate is open.
        wd = 1'b1; rh = 1'b0; ln = 1'b1; ht = 1'b0; veh_valid = 1'b1;
        tick;
        veh_valid = 1'b0; coin_valid = 1'b1; coin_value = 4'd1;
        tick;
        coin_valid = 1'b0;
        total++;
        if (gate_open !== 1'b1) begin
            bad++; $display("FAIL rst_gate_pre got=%0b exp=1", gate_open);
        end
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_veh = 0; exp_err = 0; exp_rev = 0;
        total++;
        if ({gate_open, veh_ready, coin_ready, change_valid, rate} !== 6'b010000 ||
            veh_cnt !== 16'd0 || revenue !== 16'd0 || err_cnt !== 16'd0) begin
            bad++; $display("FAIL rst_gate got=%0b,%0d,%0d exp=010000,0,0",
                            {gate_open, veh_ready, coin_ready, change_valid, rate}, veh_cnt, revenue);
        end
        // Reset while paying with 2 collected.
        wd = 1'b1; rh = 1'b1; ln = 1'b0; ht = 1'b0; veh_valid = 1'b1;
        tick;
        veh_valid = 1'b0; coin_valid = 1'b1; coin_value = 4'd2;
        tick;
        coin_valid = 1'b0;
        total++;
        if ({coin_ready, change_valid, gate_open} !== 3'b100) begin
            bad++; $display("FAIL rst_pay_pre got=%0b exp=100", {coin_ready, change_valid, gate_open});
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        total++;
        if ({gate_open, veh_ready, coin_ready, change_valid, timeout_pulse} !== 5'b01000 ||
            amount_due !== 8'd0 || change !== 8'd0) begin
            bad++; $display("FAIL rst_pay got=%0b,%0d,%0d exp=01000,0,0",
                            {gate_open, veh_ready, coin_ready, change_valid, timeout_pulse},
                            amount_due, change);
        end
        tick;
        total++;
        if ({change_valid, timeout_pulse, veh_ready} !== 3'b001) begin
            bad++; $display("FAIL rst_pay_after got=%0b exp=001", {change_valid, timeout_pulse, veh_ready});
        end
    endtask

    task automatic test_saturation;
        do_reset();
        clear_plan();
        plan[0] = 1;
        for (int i = 0; i < 4; i++) run_vehicle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "sat");
        for (int i = 0; i < 5; i++) run_vehicle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "sat_err");
        total++;
        if (s_veh_cnt !== 2'd3 || s_revenue !== 2'd3 || s_err_cnt !== 2'd3 || veh_cnt !== 16'd4) begin
            bad++; $display("FAIL sat_final got=%0d,%0d,%0d,%0d exp=3,3,3,4",
                            s_veh_cnt, s_revenue, s_err_cnt, veh_cnt);
        end
    endtask

    task automatic test_random;
        bit a, b, c, d;
        for (int n = 0; n < 40; n++) begin
            clear_plan();
            if ($urandom_range(0, 4) != 0) begin
                for (int k = 0; k < TIMEOUT; k++) begin
                    if ($urandom_range(0, 2) == 0) plan[k] = int'($urandom_range(0, 15));
                end
            end
            {a, b, c, d} = 4'($urandom_range(0, 15));
            run_vehicle(a, b, c, d, 1'b1, "rand");
            repeat ($urandom_range(0, 2)) tick;
        end
    endtask

    initial begin
        rst = 1'b1; veh_valid = 1'b0; coin_valid = 1'b0; coin_value = 4'd0;
        wd = 1'b0; rh = 1'b0; ln = 1'b0; ht = 1'b0;
        exp_veh = 0; exp_err = 0; exp_rev = 0;
        test_reset();
        test_low();
        test_err();
        test_precedence();
        test_timeout();
        test_reset_mid();
        test_saturation();
        do_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
